uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver: deserialises the rx line into 5-8 data bits, with optional parity and 1/2 stop bits.
//  Frame format is LSB first. Timing comes from the rx_tick oversample strobe.
//  Lives inside uart_core, paired with uart_tx; delivers a word plus status flags to the register block.
//  Drives rts_n flow control to the remote transmitter.
// PARAMETERS
//  OVERSAMPLE   16  rx_tick pulses per bit period (even, >=8)
//  SYNC_STAGES  2   flip-flop stages on the rx line (>=2)
// PORTS
//  clk            in   1   single clock
//  rst_n          in   1   synchronous active-low reset
//  data_bit_num_i in   2   00=5, 01=6, 10=7, 11=8 data bits
//  parity_en_i    in   1   1 = parity bit present
//  parity_type_i  in   1   0 = even, 1 = odd
//  stop_bit_num_i in   1   0 = 1 stop bit, 1 = 2 stop bits
//  rx             in   1   serial input, idle high, asynchronous
//  rx_tick        in   1   1-clk strobe, OVERSAMPLE x baud
//  rx_read_i      in   1   1-clk pulse: register block consumed rx_data_o
//  rx_done_o      out  1   1-clk pulse: frame complete, rx_data_o/flags valid
//  rx_data_o      out  32  received bits zero-extended; held until next rx_done_o
//  parity_err_o   out  1   parity mismatch on last frame; updated with rx_done_o
//  frame_err_o    out  1   a stop bit sampled 0 on last frame; updated with rx_done_o
//  overrun_err_o  out  1   sticky: frame completed while unread data pending
//  rts_n          out  1   0 = ready to receive; 1 = unread data held
// BEHAVIOUR
//  Reset: all outputs 0 except rts_n=1; FSM=IDLE; counters 0; sync chain preset to 1.
//   rts_n falls on the first clk after reset release.
//  Sync: rx passes SYNC_STAGES flops (rx_s). Every FSM decision uses rx_s and counts only rx_tick cycles.
//  tick_cnt: counts rx_tick within a bit, 0..OVERSAMPLE-1. bit_cnt: counts data/stop bits.
//  FSM:
//   IDLE: rx_s==0 on a tick -> START, tick_cnt=0.
//   START: at tick_cnt==OVERSAMPLE/2-1 (mid start bit):
//    - rx_s==1 -> IDLE (glitch rejected, no flags).
//    - rx_s==0 -> latch all config inputs, tick_cnt=0, -> DATA.
//   DATA: sample rx_s at tick_cnt==OVERSAMPLE-1 (mid-bit), shift in LSB first.
//    After N=5+data_bit_num bits: -> PARITY if enabled, else -> STOP.
//   PARITY: sample mid-bit. Error if (^data ^ bit) != parity_type.
//   STOP: sample mid-bit; any 0 sets frame error. After 1 or 2 stop bits:
//    - go to IDLE immediately, from the mid-point of the last stop bit;
//    - pulse rx_done_o in the same cycle.
//  Latency: rx_done_o comes (SYNC_STAGES+1) clk after the rx_tick that samples the last stop bit.
//  Config changes mid-frame are ignored; the latched copy applies until IDLE.
//  On rx_done_o:
//   - rx_data_o <= {zeros, data[N-1:0]}; parity_err_o and frame_err_o are overwritten.
//   - rx_full is set.
//   - If rx_full was already set and rx_read_i is not asserted in the same cycle:
//     overrun_err_o <= 1 and the old data is overwritten.
//  rx_read_i clears rx_full and overrun_err_o.
//   - rx_read_i and rx_done_o in the same cycle: done wins, rx_full stays 1, overrun not set.
//   - rx_read_i with rx_full==0 has no effect.
//  rts_n is a registered copy of rx_full (1 clk lag). Reception continues while rts_n=1.
//  Break (rx held 0): frame completes with data 0, frame_err_o=1, then the FSM waits in IDLE for rx_s==1.
//   No new start bit is accepted until rx_s has been 1 on at least one tick.
//  rst_n low mid-frame: abort at the next clk edge, no rx_done_o; resume in IDLE.
// STRUCTURE
//  uart_pkg: rx_state_e {IDLE,START,DATA,PARITY,STOP}.
//  uart_pkg: data-bit encodings DBITS_5..DBITS_8; PARITY_EVEN/PARITY_ODD; STOP_1/STOP_2.
//  Sub-module uart_sync (SYNC_STAGES flop chain, reset value parameterised), shared with cts_n in uart_core.
// TESTING
//  - 8N1, rx sends 0xA5 -> one rx_done_o pulse; rx_data_o=0x000000A5; all errors 0; rts_n=1 one clk later.
//  - 7E2, sends 0x35 with correct parity 0 -> data 0x35, parity_err 0.
//    Same frame with parity bit 1 -> parity_err_o=1, data still 0x35.
//  - 5O1, sends 0x1F, stop bit forced 0 -> rx_data_o=0x1F, frame_err_o=1.
//    Then rx idle high, next frame received cleanly.
//  - Low glitch of 3 ticks on idle rx -> no rx_done_o, FSM back in IDLE.
//  - Two 8N1 frames with no rx_read_i -> 2nd rx_done_o sets overrun_err_o=1, data = 2nd byte.
//    Then rx_read_i -> overrun 0, rts_n 0.
//    Repeat with rx_read_i coincident with the 2nd done -> no overrun.
//  - rst_n low during bit 4, then a clean 0x3C frame -> no done for the aborted frame; 0x3C received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and encodings: receiver FSM states and the frame-format
// field encodings used by the register block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    // Index of the last data bit for a data-bit-count encoding (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] dbits);
        return 3'd4 + {1'b0, dbits};
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; the reset
// value is a parameter so idle-high lines do not see a false edge after reset.
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop deserialiser with
// frame/parity/overrun status and rts_n flow control.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  data_bit_num_i,
    input  logic        parity_en_i,
    input  logic        parity_type_i,
    input  logic        stop_bit_num_i,
    input  logic        rx,
    input  logic        rx_tick,
    input  logic        rx_read_i,
    output logic        rx_done_o,
    output logic [31:0] rx_data_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overrun_err_o,
    output logic        rts_n
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic                   w_rx_s;
    logic                   w_tick;
    logic                   w_mid_bit;
    logic                   w_frame_end;
    logic [SYNC_STAGES-1:0] r_tick_dly;

    rx_state_e              r_state;
    logic [TW-1:0]          r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic [2:0]             r_last_bit;
    logic                   r_par_en;
    logic                   r_par_type;
    logic                   r_stop2;
    logic [7:0]             r_shift;
    logic                   r_par_acc;
    logic                   r_frm_acc;
    logic                   r_armed;

    logic                   r_done;
    logic [7:0]             r_data;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_full;
    logic                   r_was_full;
    logic                   r_overrun;
    logic                   r_rts_n;

    uart_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // The tick is delayed by the synchroniser depth so each tick samples the
    // rx level that was on the pin when the tick was issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_dly <= '0;
        end else begin
            r_tick_dly <= {r_tick_dly[SYNC_STAGES-2:0], rx_tick};
        end
    end

    assign w_tick      = r_tick_dly[SYNC_STAGES-1];
    assign w_mid_bit   = w_tick && (r_tick_cnt == TICK_LAST);
    assign w_frame_end = (r_state == STOP) && w_mid_bit && (r_bit_cnt == {2'b00, r_stop2});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_last_bit   <= '0;
            r_par_en     <= 1'b0;
            r_par_type   <= 1'b0;
            r_stop2      <= 1'b0;
            r_par_acc    <= 1'b0;
            r_frm_acc    <= 1'b0;
            r_armed      <= 1'b0;
            r_done       <= 1'b0;
            r_data       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // A start bit is only accepted once the line has been seen high.
                IDLE: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state    <= START;
                            r_tick_cnt <= '0;
                        end
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TICK_MID) begin
                            r_tick_cnt <= '0;
                            if (w_rx_s) begin
                                r_state <= IDLE;
                            end else begin
                                r_state    <= DATA;
                                r_last_bit <= last_bit_idx(data_bit_num_i);
                                r_par_en   <= parity_en_i;
                                r_par_type <= parity_type_i;
                                r_stop2    <= (stop_bit_num_i == STOP_2);
                                r_bit_cnt  <= '0;
                                r_shift    <= '0;
                                r_par_acc  <= 1'b0;
                                r_frm_acc  <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_mid_bit) begin
                        r_tick_cnt           <= '0;
                        r_shift[r_bit_cnt]   <= w_rx_s;
                        if (r_bit_cnt == r_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_mid_bit) begin
                        r_tick_cnt <= '0;
                        r_par_acc  <= ((^r_shift) ^ w_rx_s) != r_par_type;
                        r_state    <= STOP;
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                // The frame closes at the middle of the last stop bit.
                STOP: begin
                    if (w_frame_end) begin
                        r_tick_cnt   <= '0;
                        r_state      <= IDLE;
                        r_armed      <= 1'b0;
                        r_done       <= 1'b1;
                        r_data       <= r_shift;
                        r_parity_err <= r_par_acc;
                        r_frame_err  <= r_frm_acc | ~w_rx_s;
                    end else if (w_mid_bit) begin
                        r_tick_cnt <= '0;
                        r_frm_acc  <= r_frm_acc | ~w_rx_s;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Overrun is judged while rx_done_o is high so a read issued with the done pulse still counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full     <= 1'b0;
            r_was_full <= 1'b0;
            r_overrun  <= 1'b0;
            r_rts_n    <= 1'b1;
        end else begin
            r_rts_n <= r_full;
            if (w_frame_end) begin
                r_full     <= 1'b1;
                r_was_full <= r_full & ~rx_read_i;
            end else if (r_done) begin
                if (r_was_full && !rx_read_i) begin
                    r_overrun <= 1'b1;
                end
            end else if (rx_read_i) begin
                r_full    <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_done_o     = r_done;
    assign rx_data_o     = {24'b0, r_data};
    assign parity_err_o  = r_parity_err;
    assign frame_err_o   = r_frame_err;
    assign overrun_err_o = r_overrun;
    assign rts_n         = r_rts_n;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-level frames driven on rx with a
// bench-generated rx_tick, checked against hand-computed results.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic [1:0]  data_bit_num_i;
    logic        parity_en_i;
    logic        parity_type_i;
    logic        stop_bit_num_i;
    logic        rx;
    logic        rx_tick;
    logic        rx_read_i;
    logic        rx_done_o;
    logic [31:0] rx_data_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        overrun_err_o;
    logic        rts_n;

    logic        man_rd;
    logic        auto_rd;
    logic        auto_en;
    int          total;
    int          bad;
    int          cyc;
    int          tick_cyc;
    int          stop_tick;
    int          done_cnt;
    int          done_cyc;
    logic        prev_done;
    logic        rts_at_done;
    logic        rts_after;

    assign rx_read_i = man_rd | auto_rd;

    uart_rx #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_bit_num_i (data_bit_num_i),
        .parity_en_i    (parity_en_i),
        .parity_type_i  (parity_type_i),
        .stop_bit_num_i (stop_bit_num_i),
        .rx             (rx),
        .rx_tick        (rx_tick),
        .rx_read_i      (rx_read_i),
        .rx_done_o      (rx_done_o),
        .rx_data_o      (rx_data_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .overrun_err_o  (overrun_err_o),
        .rts_n          (rts_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Done-pulse monitor: counts pulses, records timing and rts_n around each pulse.
    always @(negedge clk) begin
        auto_rd = auto_en && rx_done_o;
        if (prev_done) rts_after = rts_n;
        prev_done = rx_done_o;
        if (rx_done_o) begin
            done_cnt    = done_cnt + 1;
            done_cyc    = cyc;
            rts_at_done = rts_n;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick_pulse();
        @(negedge clk);
        rx_tick  = 1'b1;
        tick_cyc = cyc;
        @(negedge clk);
        rx_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        repeat (n) tick_pulse();
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic pe, input logic pt, input logic sb);
        data_bit_num_i = db;
        parity_en_i    = pe;
        parity_type_i  = pt;
        stop_bit_num_i = sb;
    endtask

    task automatic read_pulse();
        @(negedge clk);
        man_rd = 1'b1;
        @(negedge clk);
        man_rd = 1'b0;
    endtask

    // Sends start + nbits data (LSB first) + optional parity + nstop stop bits.
    // abort_bit >= 0 pulses rst_n low part-way through that frame bit.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input int nstop, input logic stop_val,
                              input int abort_bit, input logic scramble);
        logic [11:0] b;
        logic [1:0]  sv_db;
        logic        sv_pe, sv_pt, sv_sb;
        int          n;
        sv_db = data_bit_num_i;
        sv_pe = parity_en_i;
        sv_pt = parity_type_i;
        sv_sb = stop_bit_num_i;
        b = '0;
        n = 1;
        for (int i = 0; i < nbits; i++) begin
            b[n] = d[i];
            n++;
        end
        if (par_en) begin
            b[n] = par_bit;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            b[n] = stop_val;
            n++;
        end
        for (int k = 0; k < n; k++) begin
            rx = b[k];
            for (int t = 0; t < 16; t++) begin
                if (k == abort_bit && t == 4) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    rx    = 1'b1;
                    return;
                end
                tick_pulse();
                if (k == n - 1 && t == 8) stop_tick = tick_cyc;
                if (scramble && k == 1 && t == 0) begin
                    set_cfg(~sv_db, ~sv_pe, ~sv_pt, ~sv_sb);
                end
            end
        end
        set_cfg(sv_db, sv_pe, sv_pt, sv_sb);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (rx_done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", rx_done_o); end
        total++; if (rx_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", rx_data_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err_o); end
        total++; if (overrun_err_o !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun_err_o); end
        total++; if (rts_n !== 1'b1) begin bad++; $display("FAIL reset_rts got=%b want=1", rts_n); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (rts_n !== 1'b0) begin bad++; $display("FAIL reset_rts_release got=%b want=0", rts_n); end
    endtask

    task automatic test_8n1();
        int d0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle_ticks(4);
        d0 = done_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        idle_ticks(2);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL 8n1_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h000000A5) begin bad++; $display("FAIL 8n1_data got=%h want=000000a5", rx_data_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL 8n1_perr got=%b want=0", parity_err_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL 8n1_ferr got=%b want=0", frame_err_o); end
        total++; if (overrun_err_o !== 1'b0) begin bad++; $display("FAIL 8n1_ovr got=%b want=0", overrun_err_o); end
        total++; if (done_cyc - stop_tick !== 3) begin bad++; $display("FAIL 8n1_latency got=%0d want=3", done_cyc - stop_tick); end
        total++; if (rts_at_done !== 1'b0) begin bad++; $display("FAIL 8n1_rts_at_done got=%b want=0", rts_at_done); end
        total++; if (rts_after !== 1'b1) begin bad++; $display("FAIL 8n1_rts_after got=%b want=1", rts_after); end
        read_pulse();
        @(negedge clk);
        total++; if (rts_n !== 1'b0) begin bad++; $display("FAIL 8n1_rts_read got=%b want=0", rts_n); end
    endtask

    task automatic test_parity();
        int d0;
        set_cfg(2'b10, 1'b1, 1'b0, 1'b1);
        idle_ticks(4);
        d0 = done_cnt;
        send_frame(8'h35, 7, 1'b1, 1'b0, 2, 1'b1, -1, 1'b0);
        idle_ticks(2);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL 7e2_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h35) begin bad++; $display("FAIL 7e2_data got=%h want=35", rx_data_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL 7e2_perr_good got=%b want=0", parity_err_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL 7e2_ferr got=%b want=0", frame_err_o); end
        read_pulse();
        idle_ticks(2);
        send_frame(8'h35, 7, 1'b1, 1'b1, 2, 1'b1, -1, 1'b0);
        idle_ticks(2);
        total++; if (rx_data_o !== 32'h35) begin bad++; $display("FAIL 7e2_bad_data got=%h want=35", rx_data_o); end
        total++; if (parity_err_o !== 1'b1) begin bad++; $display("FAIL 7e2_perr_bad got=%b want=1", parity_err_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL 7e2_bad_ferr got=%b want=0", frame_err_o); end
        read_pulse();
    endtask

    task automatic test_frame_err();
        int d0;
        set_cfg(2'b00, 1'b1, 1'b1, 1'b0);
        idle_ticks(4);
        d0 = done_cnt;
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1, 1'b0, -1, 1'b0);
        idle_ticks(2);
        total++; if (rx_data_o !== 32'h1F) begin bad++; $display("FAIL 5o1_data got=%h want=1f", rx_data_o); end
        total++; if (frame_err_o !== 1'b1) begin bad++; $display("FAIL 5o1_ferr got=%b want=1", frame_err_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL 5o1_perr got=%b want=0", parity_err_o); end
        read_pulse();
        idle_ticks(4);
        send_frame(8'h0A, 5, 1'b1, 1'b1, 1, 1'b1, -1, 1'b0);
        idle_ticks(2);
        total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL 5o1_pulses got=%0d want=2", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h0A) begin bad++; $display("FAIL 5o1_clean_data got=%h want=0a", rx_data_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL 5o1_clean_ferr got=%b want=0", frame_err_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL 5o1_clean_perr got=%b want=0", parity_err_o); end
        read_pulse();
    endtask

    task automatic test_break();
        int d0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle_ticks(4);
        d0 = done_cnt;
        send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b0, -1, 1'b0);
        rx = 1'b0;
        repeat (40) tick_pulse();
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL break_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h0) begin bad++; $display("FAIL break_data got=%h want=0", rx_data_o); end
        total++; if (frame_err_o !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b want=1", frame_err_o); end
        read_pulse();
        idle_ticks(4);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        idle_ticks(2);
        total++; if (rx_data_o !== 32'h81) begin bad++; $display("FAIL break_next_data got=%h want=81", rx_data_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL break_next_ferr got=%b want=0", frame_err_o); end
        read_pulse();
    endtask

    task automatic test_glitch();
        int d0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle_ticks(4);
        d0 = done_cnt;
        rx = 1'b0;
        repeat (3) tick_pulse();
        idle_ticks(30);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", done_cnt - d0); end
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        idle_ticks(2);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL glitch_next_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h5A) begin bad++; $display("FAIL glitch_next_data got=%h want=5a", rx_data_o); end
        read_pulse();
    endtask

    task automatic test_back_to_back();
        int d0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle_ticks(4);
        d0 = done_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        idle_ticks(2);
        total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h22) begin bad++; $display("FAIL b2b_data got=%h want=22", rx_data_o); end
        total++; if (overrun_err_o !== 1'b1) begin bad++; $display("FAIL b2b_ovr_set got=%b want=1", overrun_err_o); end
        total++; if (rts_n !== 1'b1) begin bad++; $display("FAIL b2b_rts_full got=%b want=1", rts_n); end
        read_pulse();
        total++; if (overrun_err_o !== 1'b0) begin bad++; $display("FAIL b2b_ovr_clr got=%b want=0", overrun_err_o); end
        @(negedge clk);
        total++; if (rts_n !== 1'b0) begin bad++; $display("FAIL b2b_rts_read got=%b want=0", rts_n); end
        idle_ticks(2);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        auto_en = 1'b1;
        send_frame(8'h44, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        idle_ticks(2);
        auto_en = 1'b0;
        total++; if (rx_data_o !== 32'h44) begin bad++; $display("FAIL coinc_data got=%h want=44", rx_data_o); end
        total++; if (overrun_err_o !== 1'b0) begin bad++; $display("FAIL coinc_ovr got=%b want=0", overrun_err_o); end
        total++; if (rts_n !== 1'b1) begin bad++; $display("FAIL coinc_rts got=%b want=1", rts_n); end
        read_pulse();
        @(negedge clk);
        total++; if (rts_n !== 1'b0) begin bad++; $display("FAIL coinc_rts_read got=%b want=0", rts_n); end
    endtask

    task automatic test_reset_abort();
        int d0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle_ticks(4);
        d0 = done_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 5, 1'b0);
        idle_ticks(40);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h0) begin bad++; $display("FAIL abort_data got=%h want=0", rx_data_o); end
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b1);
        idle_ticks(2);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_next_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (rx_data_o !== 32'h3C) begin bad++; $display("FAIL abort_next_data got=%h want=3c", rx_data_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL abort_next_perr got=%b want=0", parity_err_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL abort_next_ferr got=%b want=0", frame_err_o); end
        read_pulse();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        tick_cyc    = 0;
        stop_tick   = 0;
        done_cnt    = 0;
        done_cyc    = 0;
        prev_done   = 1'b0;
        rts_at_done = 1'b0;
        rts_after   = 1'b0;
        man_rd      = 1'b0;
        auto_rd     = 1'b0;
        auto_en     = 1'b0;
        rx          = 1'b1;
        rx_tick     = 1'b0;
        rst_n       = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
